// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decode, derives the ALU op code, forwards final ALU operands.
// Latency: one cycle from decode capture to ex_* outputs; a/b/store_data/ALUop follow forwarding combinationally.
// Backpressure: stall holds every registered field, flush loads a bubble and wins over stall.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [63:0] dec_pc,
    input  logic [63:0] dec_rs1_data,
    input  logic [63:0] dec_rs2_data,
    input  logic [63:0] dec_imm,
    input  logic [4:0]  dec_rs1,
    input  logic [4:0]  dec_rs2,
    input  logic [4:0]  dec_rd,
    input  logic [2:0]  dec_funct3,
    input  logic        dec_funct7b5,
    input  logic [1:0]  dec_ALUOp,
    input  logic        dec_ALUSrc,
    input  logic        dec_RegWrite,
    input  logic        dec_MemRead,
    input  logic        dec_MemWrite,
    input  logic        dec_MemtoReg,
    input  logic        dec_Branch,
    input  logic [4:0]  exm_rd,
    input  logic        exm_RegWrite,
    input  logic [63:0] exm_result,
    input  logic [4:0]  mwb_rd,
    input  logic        mwb_RegWrite,
    input  logic [63:0] mwb_result,
    output logic [63:0] a,
    output logic [63:0] b,
    output logic [3:0]  ALUop,
    output logic [63:0] store_data,
    output logic [63:0] ex_pc,
    output logic [63:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_funct3,
    output logic        ex_valid,
    output logic        ex_RegWrite,
    output logic        ex_MemRead,
    output logic        ex_MemWrite,
    output logic        ex_MemtoReg,
    output logic        ex_Branch,
    output logic        load_use
);

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic [1:0]  alu_op;
        logic        alu_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        branch;
    } idex_t;

    idex_t st_q, st_d;

    // EX/MEM wins over MEM/WB; x0 is never forwarded because it always reads as zero upstream.
    function automatic logic [63:0] fwd(input logic [4:0] r, input logic [63:0] rf,
                                        input logic e_we, input logic [4:0] e_rd, input logic [63:0] e_res,
                                        input logic m_we, input logic [4:0] m_rd, input logic [63:0] m_res);
        logic [63:0] v;
        v = rf;
        if (e_we && (e_rd == r) && (r != 5'd0))
            v = e_res;
        else if (m_we && (m_rd == r) && (r != 5'd0))
            v = m_res;
        return v;
    endfunction

    // Next state: flush bubble beats stall hold beats capture; non-valid captures carry no controls.
    always_comb begin
        st_d = st_q;
        if (flush) begin
            st_d = '0;
        end else if (!stall) begin
            st_d.valid      = in_valid;
            st_d.pc         = dec_pc;
            st_d.rs1_data   = dec_rs1_data;
            st_d.rs2_data   = dec_rs2_data;
            st_d.imm        = dec_imm;
            st_d.rs1        = dec_rs1;
            st_d.rs2        = dec_rs2;
            st_d.rd         = dec_rd;
            st_d.funct3     = dec_funct3;
            st_d.funct7b5   = dec_funct7b5;
            st_d.alu_op     = dec_ALUOp;
            st_d.alu_src    = in_valid & dec_ALUSrc;
            st_d.reg_write  = in_valid & dec_RegWrite;
            st_d.mem_read   = in_valid & dec_MemRead;
            st_d.mem_write  = in_valid & dec_MemWrite;
            st_d.mem_to_reg = in_valid & dec_MemtoReg;
            st_d.branch     = in_valid & dec_Branch;
        end
    end

    // Pipeline register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            st_q <= '0;
        else
            st_q <= st_d;
    end

    logic [63:0] fwd_rs1, fwd_rs2;

    // Resolve forwarding for both source registers; stays live while stalled.
    always_comb begin
        fwd_rs1 = fwd(st_q.rs1, st_q.rs1_data, exm_RegWrite, exm_rd, exm_result,
                      mwb_RegWrite, mwb_rd, mwb_result);
        fwd_rs2 = fwd(st_q.rs2, st_q.rs2_data, exm_RegWrite, exm_rd, exm_result,
                      mwb_RegWrite, mwb_rd, mwb_result);
    end

    assign a          = fwd_rs1;
    assign store_data = fwd_rs2;
    assign b          = st_q.alu_src ? st_q.imm : fwd_rs2;

    // ALU op decode; only R-type uses funct7b5 to pick sub over add.
    always_comb begin
        ALUop = 4'b0010;
        case (st_q.alu_op)
            2'b00: ALUop = 4'b0010;
            2'b01: ALUop = 4'b0110;
            default: begin
                case (st_q.funct3)
                    3'b000:  ALUop = (st_q.alu_op == 2'b10 && st_q.funct7b5) ? 4'b0110 : 4'b0010;
                    3'b111:  ALUop = 4'b0000;
                    3'b110:  ALUop = 4'b0001;
                    3'b001:  ALUop = 4'b0111;
                    default: ALUop = 4'b0010;
                endcase
            end
        endcase
    end

    assign ex_pc       = st_q.pc;
    assign ex_imm      = st_q.imm;
    assign ex_rd       = st_q.rd;
    assign ex_funct3   = st_q.funct3;
    assign ex_valid    = st_q.valid;
    assign ex_RegWrite = st_q.reg_write;
    assign ex_MemRead  = st_q.mem_read;
    assign ex_MemWrite = st_q.mem_write;
    assign ex_MemtoReg = st_q.mem_to_reg;
    assign ex_Branch   = st_q.branch;

    // Load-use compares the registered load against the live decode indices.
    assign load_use = st_q.valid & st_q.mem_read & (st_q.rd != 5'd0) &
                      ((st_q.rd == dec_rs1) | (st_q.rd == dec_rs2));

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
    logic        clk, reset, stall, flush, in_valid;
    logic [63:0] dec_pc, dec_rs1_data, dec_rs2_data, dec_imm;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd;
    logic [2:0]  dec_funct3;
    logic        dec_funct7b5;
    logic [1:0]  dec_ALUOp;
    logic        dec_ALUSrc, dec_RegWrite, dec_MemRead, dec_MemWrite, dec_MemtoReg, dec_Branch;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_RegWrite, mwb_RegWrite;
    logic [63:0] exm_result, mwb_result;
    logic [63:0] a, b, store_data, ex_pc, ex_imm;
    logic [3:0]  ALUop;
    logic [4:0]  ex_rd;
    logic [2:0]  ex_funct3;
    logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, load_use;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    id_ex_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .dec_pc(dec_pc), .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data), .dec_imm(dec_imm),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_funct3(dec_funct3), .dec_funct7b5(dec_funct7b5), .dec_ALUOp(dec_ALUOp),
        .dec_ALUSrc(dec_ALUSrc), .dec_RegWrite(dec_RegWrite), .dec_MemRead(dec_MemRead),
        .dec_MemWrite(dec_MemWrite), .dec_MemtoReg(dec_MemtoReg), .dec_Branch(dec_Branch),
        .exm_rd(exm_rd), .exm_RegWrite(exm_RegWrite), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_RegWrite(mwb_RegWrite), .mwb_result(mwb_result),
        .a(a), .b(b), .ALUop(ALUop), .store_data(store_data),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
        .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
        .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .load_use(load_use)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [63:0] obs);
        logic [63:0] e;
        string       t;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0;
        dec_pc = 0; dec_rs1_data = 0; dec_rs2_data = 0; dec_imm = 0;
        dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; dec_funct3 = 0; dec_funct7b5 = 0; dec_ALUOp = 0;
        dec_ALUSrc = 0; dec_RegWrite = 0; dec_MemRead = 0; dec_MemWrite = 0; dec_MemtoReg = 0; dec_Branch = 0;
        exm_rd = 0; exm_RegWrite = 0; exm_result = 0;
        mwb_rd = 0; mwb_RegWrite = 0; mwb_result = 0;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] tbl_op [10];
        logic [2:0] tbl_f3 [10];
        logic       tbl_f7 [10];
        logic [3:0] tbl_exp[10];
        tbl_op = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b01};
        tbl_f3 = '{3'b111, 3'b110, 3'b000, 3'b100, 3'b001, 3'b000, 3'b111, 3'b110, 3'b101, 3'b000};
        tbl_f7 = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl_exp = '{4'b0000, 4'b0001, 4'b0010, 4'b0010, 4'b0111, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0110};

        // Reset state at time zero.
        reset = 0;
        idle_inputs();
        #1;
        push("rst_a", 0); push("rst_b", 0); push("rst_aluop", 4'b0010); push("rst_valid", 0);
        chk(a); chk(b); chk(ALUop); chk(ex_valid);
        @(negedge clk);
        reset = 1;

        // R-type sub.
        @(negedge clk);
        in_valid = 1; dec_ALUOp = 2'b10; dec_funct3 = 3'b000; dec_funct7b5 = 1;
        dec_rs1 = 1; dec_rs2 = 2; dec_rd = 3; dec_rs1_data = 10; dec_rs2_data = 3;
        dec_RegWrite = 1; dec_pc = 64'h100;
        push("sub_aluop", 4'b0110); push("sub_a", 10); push("sub_b", 3);
        push("sub_valid", 1); push("sub_pc", 64'h100); push("sub_regwrite", 1);
        edge_settle();
        chk(ALUop); chk(a); chk(b); chk(ex_valid); chk(ex_pc); chk(ex_RegWrite);

        // Forward priority on rs1.
        @(negedge clk);
        idle_inputs(); in_valid = 1; dec_rs1 = 5; dec_rs1_data = 64'h11; dec_rd = 1;
        exm_rd = 5; exm_RegWrite = 1; exm_result = 64'hAA;
        mwb_rd = 5; mwb_RegWrite = 1; mwb_result = 64'hBB;
        push("fwd_exm_a", 64'hAA); push("fwd_aluop_add", 4'b0010);
        edge_settle();
        chk(a); chk(ALUop);
        @(negedge clk);
        stall = 1; exm_RegWrite = 0;
        push("fwd_mwb_a_stalled", 64'hBB);
        edge_settle();
        chk(a);
        @(negedge clk);
        stall = 0; dec_rs1 = 0; dec_rs1_data = 64'h77;
        exm_rd = 0; exm_RegWrite = 1; mwb_rd = 0; mwb_RegWrite = 1;
        push("fwd_x0_a", 64'h77);
        edge_settle();
        chk(a);

        // I-type with immediate and forwarded store data.
        @(negedge clk);
        idle_inputs(); in_valid = 1; dec_ALUOp = 2'b11; dec_funct3 = 3'b001; dec_imm = 4; dec_ALUSrc = 1;
        dec_rs1 = 2; dec_rs1_data = 64'h55; dec_rs2 = 6; dec_rs2_data = 64'h99;
        exm_rd = 6; exm_RegWrite = 1; exm_result = 64'h1234;
        push("itype_aluop", 4'b0111); push("itype_b", 4); push("itype_store", 64'h1234);
        push("itype_a", 64'h55); push("itype_imm", 4);
        edge_settle();
        chk(ALUop); chk(b); chk(store_data); chk(a); chk(ex_imm);

        // Load-use detection with live decode indices, then stall hold.
        @(negedge clk);
        idle_inputs(); in_valid = 1; dec_MemRead = 1; dec_RegWrite = 1; dec_rd = 7; dec_pc = 64'h400;
        edge_settle();
        @(negedge clk);
        dec_rs1 = 1; dec_rs2 = 7;
        push("lu_hit_rs2", 1);
        #1 chk(load_use);
        dec_rs2 = 8; dec_rs1 = 7;
        push("lu_hit_rs1", 1);
        #1 chk(load_use);
        dec_rs1 = 8;
        push("lu_miss", 0);
        #1 chk(load_use);
        stall = 1; dec_pc = 64'h500; dec_rd = 9; dec_MemRead = 0;
        push("stall_pc", 64'h400); push("stall_rd", 7); push("stall_memread", 1);
        edge_settle();
        chk(ex_pc); chk(ex_rd); chk(ex_MemRead);
        @(negedge clk);
        stall = 0; dec_MemRead = 1; dec_rd = 0; dec_rs1 = 0; dec_rs2 = 0;
        edge_settle();
        push("lu_rd0", 0);
        chk(load_use);

        // Flush together with stall and a pending valid capture.
        @(negedge clk);
        idle_inputs(); flush = 1; stall = 1; in_valid = 1; dec_RegWrite = 1; dec_MemRead = 1;
        dec_Branch = 1; dec_rd = 9; dec_pc = 64'h700;
        push("flush_valid", 0); push("flush_regwrite", 0); push("flush_memread", 0);
        push("flush_branch", 0); push("flush_rd", 0); push("flush_pc", 0);
        edge_settle();
        chk(ex_valid); chk(ex_RegWrite); chk(ex_MemRead); chk(ex_Branch); chk(ex_rd); chk(ex_pc);

        // Non-valid capture: data loads, controls do not.
        @(negedge clk);
        idle_inputs(); in_valid = 0; dec_RegWrite = 1; dec_MemWrite = 1; dec_MemtoReg = 1;
        dec_Branch = 1; dec_ALUSrc = 1; dec_imm = 64'h3C; dec_rs2_data = 64'h21;
        dec_pc = 64'h600; dec_rd = 4; dec_funct3 = 3'b101;
        push("inv_valid", 0); push("inv_regwrite", 0); push("inv_memwrite", 0);
        push("inv_memtoreg", 0); push("inv_branch", 0); push("inv_pc", 64'h600);
        push("inv_rd", 4); push("inv_funct3", 3'b101); push("inv_b_no_alusrc", 64'h21);
        edge_settle();
        chk(ex_valid); chk(ex_RegWrite); chk(ex_MemWrite); chk(ex_MemtoReg); chk(ex_Branch);
        chk(ex_pc); chk(ex_rd); chk(ex_funct3); chk(b);

        // ALU op decode table.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            idle_inputs(); in_valid = 1;
            dec_ALUOp = tbl_op[i]; dec_funct3 = tbl_f3[i]; dec_funct7b5 = tbl_f7[i];
            push($sformatf("aluop_tbl%0d", i), {60'd0, tbl_exp[i]});
            edge_settle();
            chk(ALUop);
        end

        // Asynchronous reset mid-cycle with nonzero state.
        @(negedge clk);
        idle_inputs(); in_valid = 1; dec_ALUOp = 2'b10; dec_funct3 = 3'b111; dec_rs1 = 3;
        dec_rs1_data = 64'hDEAD; dec_imm = 64'h8; dec_ALUSrc = 1; dec_RegWrite = 1; dec_MemRead = 1;
        dec_rd = 5; dec_pc = 64'h900;
        push("pre_rst_aluop", 4'b0000); push("pre_rst_a", 64'hDEAD);
        edge_settle();
        chk(ALUop); chk(a);
        #2 reset = 0;
        dec_rs1 = 5;
        #1;
        push("arst_valid", 0); push("arst_aluop", 4'b0010); push("arst_a", 0); push("arst_b", 0);
        push("arst_pc", 0); push("arst_regwrite", 0); push("arst_memread", 0);
        push("arst_store", 0); push("arst_load_use", 0);
        chk(ex_valid); chk(ALUop); chk(a); chk(b); chk(ex_pc); chk(ex_RegWrite); chk(ex_MemRead);
        chk(store_data); chk(load_use);

        // Leftover expectations mean a step never reached its comparison.
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-delivery stage that sits directly upstream of the 64-bit ALU. It registers decoded operands and control, derives the ALU's 4-bit operation code from ALUOp/funct fields, and resolves EX/MEM and MEM/WB forwarding so the ALU receives final `a`/`b` operands. It also flags load-use hazards, and supports stall (hold) and flush (bubble) from hazard/branch logic.

## Interface
- No parameters; all datapaths fixed at 64 bits, register indices at 5 bits.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `stall` in 1: hold all registered state this edge.
- `flush` in 1: load a bubble this edge; overrides `stall`.
- `in_valid` in 1: decode stage presents a real instruction.
- `dec_pc`, `dec_rs1_data`, `dec_rs2_data`, `dec_imm` in 64 each: decode-stage values.
- `dec_rs1`, `dec_rs2`, `dec_rd` in 5 each: register indices.
- `dec_funct3` in 3; `dec_funct7b5` in 1 (instr[30]); `dec_ALUOp` in 2.
- `dec_ALUSrc`, `dec_RegWrite`, `dec_MemRead`, `dec_MemWrite`, `dec_MemtoReg`, `dec_Branch` in 1 each.
- `exm_rd` in 5, `exm_RegWrite` in 1, `exm_result` in 64: EX/MEM forwarding source.
- `mwb_rd` in 5, `mwb_RegWrite` in 1, `mwb_result` in 64: MEM/WB forwarding source.
- `a`, `b` out 64: ALU operands (combinational from registered state and forwarding).
- `ALUop` out 4: ALU operation code.
- `store_data` out 64: forwarded rs2 for stores.
- `ex_pc`, `ex_imm` out 64; `ex_rd` out 5; `ex_funct3` out 3.
- `ex_valid`, `ex_RegWrite`, `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg`, `ex_Branch` out 1 each.
- `load_use` out 1: combinational load-use hazard flag to hazard unit.

## Operation
- Register update priority at each rising `clk`: `flush` > `stall` > capture.
- Flush: every registered field cleared to 0 (valid, controls, data, indices).
- Stall: every registered field holds.
- Capture with `in_valid`=1: all `dec_*` fields loaded, `ex_valid`=1.
- Capture with `in_valid`=0: data/index fields loaded; `ex_valid` and all six control bits forced to 0.
- Forwarding per source register r (rs1_q or rs2_q): if `exm_RegWrite` and `exm_rd`==r and r!=0 use `exm_result`; else if `mwb_RegWrite` and `mwb_rd`==r and r!=0 use `mwb_result`; else registered register data. EX/MEM has priority when both match.
- `a` = fwd(rs1); `store_data` = fwd(rs2); `b` = ALUSrc_q ? imm_q : fwd(rs2).
- ALUop decode from registered ALUOp/funct3/funct7b5:
  - ALUOp 00 (load/store) -> 0010 add; 01 (branch) -> 0110 sub.
  - ALUOp 10 (R-type): f3 000 f7b5 0 -> 0010, f7b5 1 -> 0110; f3 111 -> 0000; f3 110 -> 0001; f3 001 -> 0111; other f3 -> 0010.
  - ALUOp 11 (I-type): f3 000 -> 0010 (f7b5 ignored); 111 -> 0000; 110 -> 0001; 001 -> 0111; other -> 0010.
- `load_use` = ex_valid & ex_MemRead & ex_rd!=0 & (ex_rd==dec_rs1 | ex_rd==dec_rs2); uses live decode indices, not registered ones.

## Timing
- Latency: decode inputs appear on `ex_*` one cycle after capture edge; `a`, `b`, `ALUop`, `store_data` valid in that same cycle, combinationally following forwarding inputs within it.
- Reset asserted: immediately (no clock) all registered fields 0; outputs: `a`=0, `b`=0, `store_data`=0, `ALUop`=0010, all `ex_*`=0, `load_use`=0.
- Reset deasserted mid-stream: first capture occurs at the first rising edge with `reset` high.
- `flush` and `stall` both high: bubble loaded.
- Stalled cycles keep forwarding live: operands may change if `exm_*`/`mwb_*` change while held.
- x0 never forwarded even when a source writes rd=0.

## Test plan
- Reset: pull `reset` low mid-cycle with nonzero registered state -> all `ex_*`=0, `ALUop`=0010, `a`=`b`=0 without a clock edge.
- R-type sub: ALUOp=10, f3=000, f7b5=1, rs1_data=10, rs2_data=3, no forwarding -> next cycle `ALUop`=0110, `a`=10, `b`=3, `ex_valid`=1.
- Forward priority: rs1=5, exm_rd=5/RegWrite=1/result=0xAA, mwb_rd=5/RegWrite=1/result=0xBB -> `a`=0xAA; drop exm_RegWrite -> `a`=0xBB; rs1=0 with both matching rd=0 -> `a`=rs1_data.
- I-type/ALUSrc: ALUOp=11, f3=001, imm=4, ALUSrc=1, rs2 forward active -> `ALUop`=0111, `b`=4, `store_data`=forwarded value.
- Load-use: registered lw with rd=7, decode rs2=7 -> `load_use`=1; with rd=0 -> 0; assert `stall` -> state held one cycle.
- Flush vs stall: both high with valid capture pending -> next cycle `ex_valid`=0, all controls 0, `ex_rd`=0; `in_valid`=0 capture -> controls 0, `ex_pc` loaded.
